// File: rtl/led_matrix_scroller_if.sv
// -----------------------------------------------------------------------------
// led_matrix_scroller_if
// Pattern-buffer write bus for led_matrix_scroller.
//
// Parameters
//   ADDR_W  width of the column address (clog2 of the buffer depth)
//   ROWS    row bits per column
//
// Signals
//   wr_en    write strobe, sampled on the scroller's rising clock edge
//   wr_addr  buffer column address; out-of-range addresses are ignored
//   wr_data  column pattern, active-low (0 = LED on)
//
// Modports
//   master  pattern-loading logic (drives the bus)
//   slave   the scroller (samples the bus)
// -----------------------------------------------------------------------------
interface led_matrix_scroller_if #(
  parameter int ADDR_W = 6,
  parameter int ROWS   = 8
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ROWS-1:0]   wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data
  );

endinterface : led_matrix_scroller_if

// File: rtl/led_matrix_scroller.sv
// -----------------------------------------------------------------------------
// led_matrix_scroller
// Scrolling driver for a column-scanned LED matrix with active-low row data.
// A MSG_LEN-column pattern buffer is shown through a COLS-wide window whose
// start column (offset) advances one column per scroll step, forward or
// backward, while the matrix is continuously multiplexed column by column.
//
// Parameters
//   ROWS      row bits per column (segout width)
//   COLS      number of scanned columns, SCAN_W = clog2(COLS)
//   MSG_LEN   pattern buffer depth in columns (>= COLS), ADDR_W = clog2(MSG_LEN)
//   SCAN_DIV  clk cycles per scanned column (>= 2)
//   STEP_DIV  clk cycles per scroll step while running (>= 2)
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   run         1 = window scrolls, 0 = window frozen (scan keeps going)
//   dir         0 = offset+1 per step, 1 = offset-1 per step
//   offset_clr  synchronous clear of offset and step prescaler
//   wr          pattern write bus (slave); instantiate the interface with
//               ADDR_W = clog2(MSG_LEN) and the same ROWS
//   segout      row drive for the column on scanout (registered)
//   scanout     column select (registered, same edge as segout)
//   step        one-cycle pulse when the offset moved by a scroll step
//   wrap        one-cycle pulse with step when that step wrapped the offset
// -----------------------------------------------------------------------------
module led_matrix_scroller #(
  parameter  int ROWS     = 8,
  parameter  int COLS     = 8,
  parameter  int MSG_LEN  = 44,
  parameter  int SCAN_DIV = 8192,
  parameter  int STEP_DIV = 8350000,
  localparam int SCAN_W   = $clog2(COLS),
  localparam int ADDR_W   = $clog2(MSG_LEN)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 dir,
  input  logic                 offset_clr,
  led_matrix_scroller_if.slave wr,
  output logic [ROWS-1:0]      segout,
  output logic [SCAN_W-1:0]    scanout,
  output logic                 step,
  output logic                 wrap
);

  localparam int SCAN_CNT_W = $clog2(SCAN_DIV);
  localparam int STEP_CNT_W = $clog2(STEP_DIV);

  localparam logic [SCAN_CNT_W-1:0] SCAN_LAST = SCAN_CNT_W'(SCAN_DIV - 1);
  localparam logic [STEP_CNT_W-1:0] STEP_LAST = STEP_CNT_W'(STEP_DIV - 1);
  localparam logic [SCAN_W-1:0]     COL_LAST  = SCAN_W'(COLS - 1);
  localparam logic [ADDR_W-1:0]     OFF_LAST  = ADDR_W'(MSG_LEN - 1);
  // Buffer depth in ADDR_W+1 bits so it stays exact when MSG_LEN is a power of two.
  localparam logic [ADDR_W:0]       LEN_EXT   = (ADDR_W + 1)'(MSG_LEN);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ROWS-1:0]       pat_mem [MSG_LEN];
  logic [SCAN_CNT_W-1:0] scan_cnt;
  logic [STEP_CNT_W-1:0] step_cnt;
  logic [ADDR_W-1:0]     offset;

  // ---------------------------------------------------------------------------
  // Next-column and buffer read index
  // ---------------------------------------------------------------------------
  logic              scan_tc;
  logic              step_tc;
  logic [SCAN_W-1:0] col_next;
  logic [ADDR_W:0]   idx_sum;
  logic [ADDR_W-1:0] rd_idx;
  logic              wr_in_range;

  assign scan_tc     = (scan_cnt == SCAN_LAST);
  assign step_tc     = (step_cnt == STEP_LAST);
  assign col_next    = (scanout == COL_LAST) ? '0 : scanout + SCAN_W'(1);
  assign wr_in_range = ({1'b0, wr.wr_addr} < LEN_EXT);

  // offset < MSG_LEN and col_next < COLS <= MSG_LEN, so the sum is below
  // 2*MSG_LEN and a single conditional subtract brings it back into range.
  always_comb begin
    // NOTE: every always_comb output gets a value on entry so no path can
    // leave it unassigned and infer a latch.
    idx_sum = {1'b0, offset} + (ADDR_W + 1)'(col_next);
    rd_idx  = ADDR_W'(idx_sum);
    if (idx_sum >= LEN_EXT) begin
      rd_idx = ADDR_W'(idx_sum - LEN_EXT);
    end
  end

  // ---------------------------------------------------------------------------
  // Column scan: free-running prescaler, scanout and segout load together so
  // the matrix never sees a column select paired with another column's data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registers are assigned with <= so every block sees the pre-edge
    // value of every other register, independent of block evaluation order.
    if (reset) begin
      scan_cnt <= '0;
      scanout  <= '0;
      segout   <= '1;
    end else if (scan_tc) begin
      scan_cnt <= '0;
      scanout  <= col_next;
      // Uses the offset in effect before this edge; a pending step lands at
      // the next column load.
      segout   <= pat_mem[rd_idx];
    end else begin
      scan_cnt <= scan_cnt + SCAN_CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Scroll step: prescaler only counts while running and keeps its partial
  // count across run/dir changes. offset_clr wins over a coinciding step.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt <= '0;
      offset   <= '0;
      step     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
      if (offset_clr) begin
        step_cnt <= '0;
        offset   <= '0;
      end else if (run) begin
        if (step_tc) begin
          step_cnt <= '0;
          step     <= 1'b1;
          if (dir) begin
            offset <= (offset == '0) ? OFF_LAST : offset - ADDR_W'(1);
            wrap   <= (offset == '0);
          end else begin
            offset <= (offset == OFF_LAST) ? '0 : offset + ADDR_W'(1);
            wrap   <= (offset == OFF_LAST);
          end
        end else begin
          step_cnt <= step_cnt + STEP_CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern buffer: read-before-write falls out of the registered read above.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the buffer is reset to blank on purpose so the matrix shows
    // nothing after reset; this keeps it in flops rather than a RAM macro.
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        pat_mem[i] <= '1;
      end
    end else if (wr.wr_en && wr_in_range) begin
      pat_mem[wr.wr_addr] <= wr.wr_data;
    end
  end

endmodule : led_matrix_scroller

// File: tb/tb_led_matrix_scroller.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_scroller
// Self-checking bench for led_matrix_scroller with small dividers. The
// reference model derives the scan column from the number of clock edges since
// reset and the scroll position from the number of running edges since the
// last clear, using plain modulo arithmetic over an array copy of the buffer.
// -----------------------------------------------------------------------------
module tb_led_matrix_scroller;

  localparam int ROWS     = 8;
  localparam int COLS     = 8;
  localparam int MSG_LEN  = 12;
  localparam int SCAN_DIV = 4;
  localparam int STEP_DIV = 64;
  localparam int ADDR_W   = $clog2(MSG_LEN);
  localparam int SCAN_W   = $clog2(COLS);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              run = 1'b0;
  logic              dir = 1'b0;
  logic              offset_clr = 1'b0;
  logic [ROWS-1:0]   segout;
  logic [SCAN_W-1:0] scanout;
  logic              step;
  logic              wrap;

  led_matrix_scroller_if #(.ADDR_W(ADDR_W), .ROWS(ROWS)) wr_bus ();

  led_matrix_scroller #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .MSG_LEN  (MSG_LEN),
    .SCAN_DIV (SCAN_DIV),
    .STEP_DIV (STEP_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .dir        (dir),
    .offset_clr (offset_clr),
    .wr         (wr_bus.slave),
    .segout     (segout),
    .scanout    (scanout),
    .step       (step),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int              m_edges;   // clock edges since reset
  int              m_run;     // running edges since reset / last clear
  int              m_off;     // window offset
  logic [ROWS-1:0] m_buf [MSG_LEN];
  logic [ROWS-1:0] m_seg;
  logic            m_step;
  logic            m_wrap;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_edges <= 0;
      m_run   <= 0;
      m_off   <= 0;
      m_seg   <= '1;
      m_step  <= 1'b0;
      m_wrap  <= 1'b0;
      foreach (m_buf[i]) m_buf[i] <= '1;
    end else begin
      m_edges <= m_edges + 1;
      if ((m_edges + 1) % SCAN_DIV == 0)
        m_seg <= m_buf[(m_off + ((m_edges + 1) / SCAN_DIV) % COLS) % MSG_LEN];
      m_step <= 1'b0;
      m_wrap <= 1'b0;
      if (offset_clr) begin
        m_run <= 0;
        m_off <= 0;
      end else if (run) begin
        m_run <= m_run + 1;
        if ((m_run + 1) % STEP_DIV == 0) begin
          m_step <= 1'b1;
          if (dir) begin
            m_off  <= (m_off + MSG_LEN - 1) % MSG_LEN;
            m_wrap <= (m_off == 0);
          end else begin
            m_off  <= (m_off + 1) % MSG_LEN;
            m_wrap <= (m_off == MSG_LEN - 1);
          end
        end
      end
      if (wr_bus.wr_en && wr_bus.wr_addr < MSG_LEN)
        m_buf[wr_bus.wr_addr] <= wr_bus.wr_data;
    end
  end

  function automatic int exp_col();
    return (m_edges / SCAN_DIV) % COLS;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside)
  // ---------------------------------------------------------------------------
  task automatic wait_col(input int c, output bit ok);
    logic [SCAN_W-1:0] prev;
    ok   = 1'b0;
    prev = scanout;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (scanout == SCAN_W'(c) && prev != SCAN_W'(c)) begin
        ok = 1'b1;
        break;
      end
      prev = scanout;
    end
  endtask

  task automatic wait_step(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (step === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic write_col(input int addr, input logic [ROWS-1:0] data);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_addr = ADDR_W'(addr);
    wr_bus.wr_data = data;
    @(negedge clk);
    wr_bus.wr_en   = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    wr_bus.wr_en   = 1'b0;
    wr_bus.wr_addr = '0;
    wr_bus.wr_data = '0;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (segout !== 8'hFF) begin errors++; $display("FAIL reset_segout: got %h expected ff", segout); end
    checks++;
    if (scanout !== '0) begin errors++; $display("FAIL reset_scanout: got %0d expected 0", scanout); end
    checks++;
    if (step !== 1'b0 || wrap !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got step=%b wrap=%b expected 0 0", step, wrap);
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      // Edge i+1 since release: column advances every SCAN_DIV edges.
      checks++;
      if (scanout !== SCAN_W'(((i + 1) / SCAN_DIV) % COLS)) begin
        errors++;
        $display("FAIL scan_sequence: cycle %0d got %0d expected %0d", i, scanout, ((i + 1) / SCAN_DIV) % COLS);
      end
      checks++;
      if (segout !== 8'hFF) begin errors++; $display("FAIL scan_blank: got %h expected ff", segout); end
    end
  endtask

  task automatic test_write_frozen();
    int pulses;
    run = 1'b0;
    for (int k = 0; k < MSG_LEN; k++) write_col(k, ROWS'(k));
    pulses = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (step === 1'b1 || wrap === 1'b1) pulses++;
      if (i >= 40) begin
        // Offset 0 and buf[k] = k: column c shows c.
        checks++;
        if (segout !== ROWS'(scanout)) begin
          errors++; $display("FAIL frozen_column: col %0d got %h expected %h", scanout, segout, ROWS'(scanout));
        end
      end
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL frozen_no_step: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_forward();
    bit ok;
    int last_cyc;
    dir = 1'b0;
    run = 1'b1;
    last_cyc = cyc;
    for (int s = 1; s <= MSG_LEN; s++) begin
      wait_step(80, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL fwd_step_timeout: step %0d got none expected pulse", s); end
      checks++;
      if (cyc - last_cyc != STEP_DIV) begin
        errors++; $display("FAIL fwd_step_period: step %0d got %0d expected %0d", s, cyc - last_cyc, STEP_DIV);
      end
      last_cyc = cyc;
      checks++;
      if (wrap !== (s == MSG_LEN)) begin
        errors++; $display("FAIL fwd_wrap: step %0d got %b expected %b", s, wrap, s == MSG_LEN);
      end
      if (s == 1) begin
        wait_col(0, ok);
        checks++;
        if (!ok || segout !== 8'h01) begin
          errors++; $display("FAIL fwd_offset1_col0: got %h expected 01", segout);
        end
      end
      if (s == 10) begin
        wait_col(7, ok);
        checks++;
        if (!ok || segout !== 8'h05) begin
          errors++; $display("FAIL fwd_offset10_col7: got %h expected 05", segout);
        end
      end
    end
    run = 1'b0;
  endtask

  task automatic test_backward();
    bit ok;
    int t0;
    dir        = 1'b1;
    run        = 1'b1;
    offset_clr = 1'b1;
    @(negedge clk);
    offset_clr = 1'b0;
    t0 = cyc;
    wait_step(80, ok);
    checks++;
    if (!ok || wrap !== 1'b1) begin
      errors++; $display("FAIL bwd_first_wrap: got step=%b wrap=%b expected 1 1", step, wrap);
    end
    checks++;
    if (cyc - t0 != STEP_DIV) begin
      errors++; $display("FAIL bwd_step_period: got %0d expected %0d", cyc - t0, STEP_DIV);
    end
    wait_col(1, ok);
    checks++;
    if (!ok || segout !== 8'h00) begin
      errors++; $display("FAIL bwd_offset11_col1: got %h expected 00", segout);
    end
    run = 1'b0;
  endtask

  task automatic test_clr_priority();
    bit ok;
    int t0;
    dir = 1'b0;
    run = 1'b1;
    ok  = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (m_run % STEP_DIV == STEP_DIV - 1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    offset_clr = 1'b1;
    @(negedge clk);
    offset_clr = 1'b0;
    t0 = cyc;
    checks++;
    if (!ok || step !== 1'b0 || wrap !== 1'b0) begin
      errors++; $display("FAIL clr_priority: got step=%b wrap=%b expected 0 0", step, wrap);
    end
    wait_step(80, ok);
    checks++;
    if (!ok || cyc - t0 != STEP_DIV) begin
      errors++; $display("FAIL clr_next_step: got %0d cycles expected %0d", cyc - t0, STEP_DIV);
    end
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL clr_step_wrap: got %b expected 0", wrap); end
    run = 1'b0;
    // Out-of-range writes must not alias onto real columns.
    write_col(MSG_LEN, 8'h00);
    write_col(15, 8'h00);
    for (int c = 0; c < COLS; c++) begin
      wait_col(c, ok);
      checks++;
      if (!ok || segout !== ROWS'((1 + c) % MSG_LEN)) begin
        errors++; $display("FAIL clr_oob_write: col %0d got %h expected %h", c, segout, ROWS'((1 + c) % MSG_LEN));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      checks++;
      if (scanout !== SCAN_W'(exp_col())) begin
        errors++; $display("FAIL rnd_scanout: cycle %0d got %0d expected %0d", i, scanout, exp_col());
      end
      checks++;
      if (segout !== m_seg) begin
        errors++; $display("FAIL rnd_segout: cycle %0d got %h expected %h", i, segout, m_seg);
      end
      checks++;
      if (step !== m_step || wrap !== m_wrap) begin
        errors++; $display("FAIL rnd_pulses: cycle %0d got %b%b expected %b%b", i, step, wrap, m_step, m_wrap);
      end
      run        = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      offset_clr = ($urandom_range(0, 99) == 0);
      wr_bus.wr_en   = ($urandom_range(0, 3) == 0);
      wr_bus.wr_addr = ADDR_W'($urandom_range(0, 15));
      wr_bus.wr_data = ROWS'($urandom);
    end
    wr_bus.wr_en = 1'b0;
    offset_clr   = 1'b0;
    run          = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int k = 0; k < MSG_LEN; k++) write_col(k, ROWS'(k));
    dir        = 1'b0;
    run        = 1'b1;
    offset_clr = 1'b1;
    @(negedge clk);
    offset_clr = 1'b0;
    for (int s = 0; s < 5; s++) wait_step(80, ok);
    wait_col(3, ok);
    checks++;
    if (!ok || segout !== 8'h08) begin
      errors++; $display("FAIL mid_offset5_col3: got %h expected 08", segout);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (segout !== 8'hFF || scanout !== '0) begin
      errors++; $display("FAIL mid_reset_async: got seg=%h scan=%0d expected ff 0", segout, scanout);
    end
    checks++;
    if (step !== 1'b0 || wrap !== 1'b0) begin
      errors++; $display("FAIL mid_reset_pulses: got %b%b expected 00", step, wrap);
    end
    run = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2 * COLS * SCAN_DIV; i++) begin
      @(negedge clk);
      checks++;
      if (segout !== 8'hFF) begin
        errors++; $display("FAIL mid_blank_after_reset: col %0d got %h expected ff", scanout, segout);
      end
      checks++;
      if (scanout !== SCAN_W'(((i + 1) / SCAN_DIV) % COLS)) begin
        errors++; $display("FAIL mid_scan_restart: got %0d expected %0d", scanout, ((i + 1) / SCAN_DIV) % COLS);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_frozen();
    test_forward();
    test_backward();
    test_clr_priority();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_led_matrix_scroller
